// File: rtl/obs_sampler_pkg.sv
// Shared types and default widths for the observation sampler.
// The state encoding keeps obs_req and out_valid as single register bits.
package obs_pkg;

    // IDLE=00, REQ=01, HOLD=10: bit 0 is obs_req, bit 1 is out_valid.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } obs_state_e;

    localparam int unsigned OBS_DATA_W_DEF  = 8;
    localparam int unsigned OBS_SEQ_W_DEF   = 8;
    localparam int unsigned OBS_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/obs_sampler_if.sv
// Bundle of the sampler's control, fetch and delivery signals.
// The master modport is the sampler's view; slave is the environment's view.
interface obs_sampler_if
    import obs_pkg::*;
#(
    parameter int DATA_W = OBS_DATA_W_DEF,
    parameter int SEQ_W  = OBS_SEQ_W_DEF
) ();

    logic              en;
    logic              pulse;
    logic              obs_req;
    logic              obs_ack;
    logic [DATA_W-1:0] obs_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SEQ_W-1:0]  out_seq;
    logic              overrun;
    logic [SEQ_W-1:0]  missed;
    logic              timeout_err;

    modport master (
        input  en, pulse, obs_ack, obs_data, out_ready,
        output obs_req, out_valid, out_data, out_seq, overrun, missed, timeout_err
    );

    modport slave (
        output en, pulse, obs_ack, obs_data, out_ready,
        input  obs_req, out_valid, out_data, out_seq, overrun, missed, timeout_err
    );

endinterface

// File: rtl/obs_timeout_cnt.sv
// Watchdog for the fetch phase: a down-counter loaded with TIMEOUT-1 while idle,
// decremented while running; expired flags the terminal count during a run.
module obs_timeout_cnt
    import obs_pkg::*;
#(
    parameter int TIMEOUT = OBS_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_zero;

    assign at_zero = (count_q == '0);
    assign expired = run && at_zero;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = LOAD;
        end else if (run && !at_zero) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= LOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/obs_sampler.sv
// Pulse-triggered req/ack fetch with valid/ready delivery, overrun reporting and
// sequence tagging. Define OBS_SAMPLER_TIMEOUT_EN to enable the fetch watchdog.
module obs_sampler
    import obs_pkg::*;
#(
    parameter int DATA_W  = OBS_DATA_W_DEF,
    parameter int TIMEOUT = OBS_TIMEOUT_DEF,
    parameter int SEQ_W   = OBS_SEQ_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    obs_sampler_if.master bus
);

    obs_state_e        state_q;
    obs_state_e        state_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;
    logic [SEQ_W-1:0]  out_seq_q;
    logic [SEQ_W-1:0]  out_seq_d;
    logic [SEQ_W-1:0]  missed_q;
    logic [SEQ_W-1:0]  missed_d;
    logic              overrun_q;
    logic              overrun_d;
    logic              timeout_err_q;
    logic              timeout_err_d;
    logic              expired;

`ifdef OBS_SAMPLER_TIMEOUT_EN
    // Held loaded outside REQ, so every REQ entry starts a fresh window.
    obs_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != REQ),
        .run     (state_q == REQ),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.en && bus.pulse) state_d = REQ;
            REQ: begin
                if (bus.obs_ack) begin
                    state_d = HOLD;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            HOLD: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_data_d    = out_data_q;
        out_seq_d     = out_seq_q;
        missed_d      = missed_q;
        overrun_d     = 1'b0;
        timeout_err_d = 1'b0;
        if (state_q == REQ) begin
            if (bus.obs_ack) begin
                out_data_d = bus.obs_data;
            end else if (expired) begin
                timeout_err_d = 1'b1;
            end
        end
        if (state_q == HOLD && bus.out_ready) begin
            out_seq_d = out_seq_q + 1'b1;
        end
        // Any pulse while busy is an overrun, even with en low.
        if (state_q != IDLE && bus.pulse) begin
            overrun_d = 1'b1;
            if (missed_q != '1) begin
                missed_d = missed_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q    <= '0;
            out_seq_q     <= '0;
            missed_q      <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            out_data_q    <= out_data_d;
            out_seq_q     <= out_seq_d;
            missed_q      <= missed_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.obs_req     = state_q[0];
    assign bus.out_valid   = state_q[1];
    assign bus.out_data    = out_data_q;
    assign bus.out_seq     = out_seq_q;
    assign bus.overrun     = overrun_q;
    assign bus.missed      = missed_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
